// File: rtl/debug_pkg.sv
// debug_pkg: shared types, widths and helpers for the debug step controller
package debug_pkg;
  typedef enum logic [1:0] {HALT = 2'd0, STEP = 2'd1, RUN = 2'd2, BREAK = 2'd3} state_t;
  localparam int XLEN_D = 32;
  localparam int NUM_CH_D = 8;
  localparam int CH_W_D = $clog2(NUM_CH_D);
  localparam int INSTR_CNT_W = 16;
  function automatic int cw(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/debug_step_ctrl_if.sv
// debug_step_ctrl_if: core-side and display-side bus between the debug controller and the core
interface debug_step_ctrl_if #(parameter int XLEN = 32, NUM_CH = 8, DIGITS = 6);
  logic [XLEN-1:0] pc;
  logic [NUM_CH*XLEN-1:0] probe_bus;
  logic core_en;
  logic [debug_pkg::INSTR_CNT_W-1:0] instr_count;
  logic [DIGITS*4-1:0] digit_val;
  modport master (input pc, probe_bus, output core_en, instr_count, digit_val);
  modport slave (output pc, probe_bus, input core_en, instr_count, digit_val);
endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchroniser, debounce filter and one-cycle press pulse for a board button
module btn_debounce
  import debug_pkg::*;
#(parameter int DEB_CYCLES = 500000) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);
  localparam int CW = cw(DEB_CYCLES);
  logic [2:0] sync;
  logic [CW-1:0] cnt;
  logic level, settle, done;
  // sync[1] is the synchronised level, sync[2] its previous sample
  assign settle = sync[2] == sync[1] && sync[1] != level;
  assign done = settle && cnt == CW'(DEB_CYCLES - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      cnt <= '0;
      level <= 1'b0;
      pulse <= 1'b0;
    end else begin
      sync <= {sync[1:0], btn};
      cnt <= settle && !done ? cnt + 1'b1 : '0;
      level <= done ? sync[2] : level;
      pulse <= done && sync[2];
    end
  end
endmodule

// File: rtl/debug_step_ctrl.sv
// debug_step_ctrl: single-step/run/breakpoint core gating and rotating probe display mux
module debug_step_ctrl
  import debug_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NUM_CH = 8,
  parameter int DIGITS = 6,
  parameter int DEB_CYCLES = 500000,
  parameter int RUN_DIV = 5000000,
  parameter int ROT_DIV = 50000000,
  localparam int CH_W = cw(NUM_CH)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic step_btn,
  input  logic run_sw,
  input  logic bp_en,
  input  logic [XLEN-1:0] bp_addr,
  input  logic [CH_W-1:0] ch_sel,
  input  logic auto_rot,
  input  logic upper_sel,
  output logic halted,
  output logic bp_hit,
  output logic [CH_W-1:0] cur_ch,
  debug_step_ctrl_if.master bus
);
  localparam int RW = cw(RUN_DIV);
  localparam int TW = cw(ROT_DIV);
  localparam int DW = DIGITS * 4;
  localparam int PW = 2 * DW > XLEN ? 2 * DW : XLEN;
  localparam logic [CH_W-1:0] LAST = CH_W'(NUM_CH - 1);
  state_t state, nxt;
  logic step_req, run_tick, rot_tick, bp_match, fire;
  logic [RW-1:0] run_cnt;
  logic [TW-1:0] rot_cnt;
  logic [XLEN-1:0] sel;
  logic [PW-1:0] ext;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step (.clk, .rst_n, .btn(step_btn), .pulse(step_req));

  assign run_tick = state == RUN && run_cnt == RW'(RUN_DIV - 1);
  assign rot_tick = rot_cnt == TW'(ROT_DIV - 1);
  assign bp_match = bp_en && bus.pc == bp_addr;

  always_comb begin
    nxt = state;
    case (state)
      HALT:  nxt = run_sw ? RUN : step_req ? STEP : HALT;
      STEP:  nxt = run_sw ? RUN : HALT;
      RUN:   nxt = !run_sw ? HALT : run_tick && bp_match ? BREAK : RUN;
      BREAK: nxt = step_req ? STEP : !run_sw ? HALT : BREAK;
    endcase
  end

  // The !core_en term keeps pulses apart even for a one-cycle run divider
  assign fire = !bus.core_en && (nxt == STEP || (state == RUN && nxt == RUN && run_tick));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HALT;
      bus.core_en <= 1'b0;
      halted <= 1'b1;
      bp_hit <= 1'b0;
      run_cnt <= '0;
      bus.instr_count <= '0;
    end else begin
      state <= nxt;
      bus.core_en <= fire;
      halted <= nxt == HALT || nxt == BREAK;
      bp_hit <= nxt == BREAK;
      run_cnt <= state == RUN && nxt == RUN && !run_tick ? run_cnt + 1'b1 : '0;
      bus.instr_count <= bus.instr_count + INSTR_CNT_W'(fire && bus.instr_count != '1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_ch <= '0;
      rot_cnt <= '0;
    end else if (!auto_rot) begin
      cur_ch <= ch_sel > LAST ? LAST : ch_sel;
      rot_cnt <= '0;
    end else begin
      cur_ch <= !rot_tick ? cur_ch : cur_ch == LAST ? '0 : cur_ch + 1'b1;
      rot_cnt <= rot_tick ? '0 : rot_cnt + 1'b1;
    end
  end

  always_comb begin
    sel = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (cur_ch == CH_W'(k)) sel = bus.probe_bus[k*XLEN +: XLEN];
  end

  // Zero-extension makes nibbles past XLEN read as 0 in the upper bank
  assign ext = PW'(sel);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.digit_val <= '0;
    else bus.digit_val <= DW'(ext >> (upper_sel ? DW : 0));
  end
endmodule

// File: tb/tb_debug_step_ctrl.sv
// tb_debug_step_ctrl: directed and randomized checks of stepping, run, breakpoint and display
module tb_debug_step_ctrl;
  localparam int XLEN = 32, NUM_CH = 3, DIGITS = 6, RUN_DIV = 3, ROT_DIV = 2;
  logic clk = 0, rst_n = 0, step_btn = 0, run_sw = 0, bp_en = 0, auto_rot = 0, upper_sel = 0;
  logic [XLEN-1:0] bp_addr = '0;
  logic [1:0] ch_sel = '0, cur_ch;
  logic halted, bp_hit;
  int n_checks = 0, n_fail = 0, pulses = 0, adj = 0, exp_instr = 0;
  bit pc_follow = 0;
  bit bounce [4] = '{1, 0, 1, 0};

  debug_step_ctrl_if #(.XLEN(XLEN), .NUM_CH(NUM_CH), .DIGITS(DIGITS)) bus ();

  debug_step_ctrl #(
    .XLEN(XLEN), .NUM_CH(NUM_CH), .DIGITS(DIGITS),
    .DEB_CYCLES(4), .RUN_DIV(RUN_DIV), .ROT_DIV(ROT_DIV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .step_btn(step_btn), .run_sw(run_sw), .bp_en(bp_en),
    .bp_addr(bp_addr), .ch_sel(ch_sel), .auto_rot(auto_rot), .upper_sel(upper_sel),
    .halted(halted), .bp_hit(bp_hit), .cur_ch(cur_ch), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n cycles, sample 1ns after each edge, model the core PC advancing on core_en
  task automatic tick(int n = 1);
    for (int i = 0; i < n; i++) begin
      logic en;
      en = bus.core_en;
      @(posedge clk); #1;
      if (pc_follow && en) bus.pc = bus.pc + 4;
      if (bus.core_en) begin
        pulses++;
        if (en) adj++;
      end
    end
  endtask

  function automatic logic [23:0] disp_model(logic [95:0] p, int ch, bit up);
    logic [31:0] w;
    logic [23:0] r;
    w = p[ch*32 +: 32];
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      int idx;
      idx = i + (up ? DIGITS : 0);
      r[i*4 +: 4] = idx < XLEN / 4 ? w[idx*4 +: 4] : 4'h0;
    end
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] exp_ch;
    bus.pc = '0;
    bus.probe_bus = '0;
    tick(3);
    check("rst_core_en", bus.core_en, 0);
    check("rst_halted", halted, 1);
    check("rst_bp_hit", bp_hit, 0);
    check("rst_cur_ch", cur_ch, 0);
    check("rst_digit_val", bus.digit_val, 0);
    check("rst_instr_count", bus.instr_count, 0);
    rst_n = 1;
    tick(2);

    // Bouncing press then a long hold must produce a single step
    pulses = 0;
    foreach (bounce[i]) begin
      step_btn = bounce[i];
      tick();
    end
    step_btn = 1;
    tick(20);
    exp_instr = 1;
    check("deb_pulses", pulses, 1);
    check("deb_instr_count", bus.instr_count, exp_instr);
    check("deb_halted", halted, 1);
    step_btn = 0;
    tick(20);
    check("deb_release_pulses", pulses, 1);

    // Free run: pulses every RUN_DIV cycles after the divider restarts on entry
    pulses = 0;
    adj = 0;
    run_sw = 1;
    tick(31);
    run_sw = 0;
    tick(3);
    exp_instr += (31 - 1) / RUN_DIV;
    check("run_pulses", pulses, (31 - 1) / RUN_DIV);
    check("run_adjacent", adj, 0);
    check("run_instr_count", bus.instr_count, exp_instr);
    check("run_halted", halted, 1);

    // Breakpoint at 0x10 with PC advancing by 4 per core_en from 0
    bus.pc = '0;
    pc_follow = 1;
    bp_en = 1;
    bp_addr = 32'h10;
    pulses = 0;
    run_sw = 1;
    for (int i = 0; i < 60 && !bp_hit; i++) tick();
    check("bp_hit", bp_hit, 1);
    check("bp_halted", halted, 1);
    check("bp_pulses", pulses, 4);
    check("bp_pc", bus.pc, 32'h10);
    tick(10);
    check("bp_hold_pulses", pulses, 4);
    step_btn = 1;
    for (int i = 0; i < 40 && pulses == 4; i++) tick();
    check("bp_step_pulses", pulses, 5);
    tick();
    check("bp_step_pc", bus.pc, 32'h14);
    check("bp_step_running", halted, 0);
    check("bp_step_cleared", bp_hit, 0);
    check("bp_step_pulses_after", pulses, 5);
    run_sw = 0;
    step_btn = 0;
    tick(10);
    exp_instr += 5;
    check("bp_instr_count", bus.instr_count, exp_instr);
    pc_follow = 0;
    bp_en = 0;

    // Directed display cases
    bus.probe_bus = {32'h0, 32'h00ABCDEF, 32'h0};
    ch_sel = 1;
    upper_sel = 0;
    tick(2);
    check("disp_ch1_cur", cur_ch, 1);
    check("disp_ch1_lower", bus.digit_val, 24'hABCDEF);
    upper_sel = 1;
    tick();
    check("disp_ch1_upper", bus.digit_val, 24'h000000);
    ch_sel = 3;
    tick();
    check("disp_clamp", cur_ch, 2);

    // Random selects and probe values; probe change must show after one cycle
    for (int n = 0; n < 20; n++) begin
      ch_sel = 2'($urandom_range(0, 3));
      upper_sel = 1'($urandom_range(0, 1));
      tick();
      bus.probe_bus = {$urandom, $urandom, $urandom};
      tick();
      exp_ch = ch_sel > 2'(NUM_CH - 1) ? 2'(NUM_CH - 1) : ch_sel;
      check("rand_cur_ch", cur_ch, exp_ch);
      check("rand_digit_val", bus.digit_val, disp_model(bus.probe_bus, int'(exp_ch), upper_sel));
    end

    // Auto rotation from channel 0
    ch_sel = 0;
    upper_sel = 0;
    tick();
    check("rot_start", cur_ch, 0);
    auto_rot = 1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("rot_seq", cur_ch, (k / ROT_DIV) % NUM_CH);
    end
    auto_rot = 0;
    tick();

    // Asynchronous reset during a run-mode core_en cycle
    run_sw = 1;
    pulses = 0;
    for (int i = 0; i < 20 && pulses == 0; i++) tick();
    check("ar_pulse_seen", bus.core_en, 1);
    rst_n = 0;
    #1;
    check("ar_core_en", bus.core_en, 0);
    check("ar_halted", halted, 1);
    check("ar_bp_hit", bp_hit, 0);
    check("ar_instr_count", bus.instr_count, 0);
    run_sw = 0;
    tick(2);
    check("ar_no_trailing", bus.core_en, 0);
    rst_n = 1;
    tick(2);
    check("ar_after_halted", halted, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/debug_step_ctrl.md
Name: debug_step_ctrl

Overview:
Debug controller between the board inputs, the single-cycle core and the six hex displays. It replaces the raw push-button core clock and the fixed switch-priority display mux with three things: a debounced single-step, a free-run mode with a PC breakpoint, and a parametrised N-channel probe selector with auto-rotation. The core runs on clk and is gated by core_en. The hex7seg instances take their inputs from digit_val.

Parameters:
XLEN, 32, probe and PC width
NUM_CH, 8, number of probe channels (2..16)
DIGITS, 6, hex digits driven
DEB_CYCLES, 500000, cycles step_btn must be stable before it is accepted
RUN_DIV, 5000000, clk cycles between core_en pulses in RUN
ROT_DIV, 50000000, clk cycles per channel in auto-rotate

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous active-low
step_btn  in  1  raw step button, asynchronous, active-high
run_sw  in  1  1 = free-run, 0 = halt/step
bp_en  in  1  breakpoint enable
bp_addr  in  XLEN  breakpoint PC
pc  in  XLEN  current core PC
probe_bus  in  NUM_CH*XLEN  channel k = bits [k*XLEN +: XLEN]
ch_sel  in  $clog2(NUM_CH)  manual channel select
auto_rot  in  1  1 = rotate channels automatically
upper_sel  in  1  0 = nibbles 0..DIGITS-1, 1 = nibbles DIGITS..2*DIGITS-1
core_en  out  1  one-cycle advance pulse to PC/regfile/data memory
halted  out  1  FSM is in HALT or BREAK
bp_hit  out  1  FSM is in BREAK
cur_ch  out  $clog2(NUM_CH)  channel currently displayed
digit_val  out  DIGITS*4  nibble per display, digit 0 = LSBs
instr_count  out  16  core_en pulses since reset, saturating

Behaviour:
- Reset: FSM=HALT; core_en=0, halted=1, bp_hit=0, cur_ch=0, digit_val=0, instr_count=0; all counters and synchronisers cleared. Asserting reset mid-step or mid-run aborts immediately, with no trailing core_en.
- step_btn path: 2-FF synchroniser, then debounce counter. The counter restarts on any change of the synced input. The stable level updates after DEB_CYCLES equal samples. step_req is a 1-cycle pulse on a 0->1 change of the stable level only. A held button gives exactly one step_req.
- FSM states HALT, STEP, RUN, BREAK:
  - HALT: step_req -> STEP. run_sw=1 -> RUN. If both occur in the same cycle, RUN wins.
  - STEP: core_en=1 for exactly this cycle. Next state is RUN if run_sw=1, else HALT.
  - RUN: run_tick pulses every RUN_DIV cycles; the divider restarts on entry to RUN. At a tick:
    - bp_en=1 and pc==bp_addr -> BREAK, no core_en.
    - otherwise core_en=1 that cycle.
    - run_sw=0 -> HALT, checked with priority over the tick.
  - BREAK: step_req -> STEP, which steps past the breakpoint. run_sw=0 -> HALT. Otherwise stay.
- step_req is ignored in RUN.
- core_en is never high for two consecutive cycles.
- instr_count increments on each core_en and saturates at 16'hFFFF.
- Channel select:
  - auto_rot=0: cur_ch follows ch_sel, registered. If ch_sel>=NUM_CH, cur_ch=NUM_CH-1.
  - auto_rot=1: cur_ch increments every ROT_DIV cycles and wraps NUM_CH-1 -> 0. The rotation divider is cleared while auto_rot=0. The rotation starts from the current cur_ch.
- Display:
  - digit_val is registered and lags the cur_ch/upper_sel/probe changes by 1 cycle.
  - Nibble i = bits [(i + upper_sel*DIGITS)*4 +: 4] of the selected channel.
  - Nibbles beyond XLEN read 0.

Decomposition:
- Package debug_pkg holds:
  - FSM state enum (HALT=2'd0, STEP=2'd1, RUN=2'd2, BREAK=2'd3)
  - the clog2-based width constants
  - INSTR_CNT_W=16
- Sub-module btn_debounce: synchroniser, debounce counter and edge pulse, parameter DEB_CYCLES. It is reused for future board buttons.
- FSM, dividers and display mux stay in debug_step_ctrl.

Test Plan:
- DEB_CYCLES=4: the stimulus is step_btn bouncing 1,0,1,0 at 1-cycle intervals, then held high for 20 cycles. Required response: exactly one core_en pulse, instr_count=1, halted=1.
- RUN_DIV=3, run_sw=1, bp_en=0 for 30 cycles: core_en pulses every 3rd cycle and instr_count=10, never two adjacent pulses.
- RUN_DIV=3, bp_en=1, bp_addr=32'h10, pc stepped by 4 from 0 on each core_en: pulses stop once pc=32'h10, with bp_hit=1 and halted=1. One step_req then gives one core_en and returns to RUN.
- NUM_CH=3, probe ch1=32'h00ABCDEF, ch_sel=1, upper_sel=0: digit_val=24'hABCDEF one cycle later. With upper_sel=1: digit_val=24'h000000. With ch_sel=3: cur_ch=2.
- NUM_CH=3, ROT_DIV=2, auto_rot=1: cur_ch sequence 0,1,2,0 at 2-cycle spacing.
- rst_n asserted asynchronously in RUN during the core_en cycle: core_en=0 immediately, FSM=HALT, instr_count=0.
